slt_iter: RTL and testbench

//  Multi-cycle signed/unsigned magnitude comparator: successor of the single-cycle

---
 rtl/slt_iter.sv | 166 ++++++++++++++++
 tb/tb_slt_iter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/slt_iter.sv
// Multi-cycle signed/unsigned comparator scanning CHUNK bits per cycle, MSB chunk first.
// Define SLT_ITER_EARLY_EXIT_EN to stop at the first differing chunk; otherwise constant-time.
module adder_n #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  logic [W:0] c_s;

  assign c_s[0] = cin;
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]     = x[i] ^ y[i] ^ c_s[i];
    assign c_s[i+1] = (x[i] & y[i]) | (c_s[i] & (x[i] ^ y[i]));
  end
  assign cout = c_s[W];
endmodule

module slt_iter #(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         is_signed,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         lt,
  output logic         eq,
  output logic         gt
);
  localparam int NC = N / CHUNK;
  localparam int IW = (NC > 1) ? $clog2(NC) : 1;
  localparam logic [IW-1:0] IDX_TOP  = IW'(NC - 1);
  localparam logic [N-1:0]  MSB_MASK = N'(1) << (N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [N-1:0]    a_q, b_q;
  logic [IW-1:0]   idx_q;
  logic            in_ready_q, out_valid_q, lt_q, eq_q, gt_q;

  logic [CHUNK-1:0] ca_s, cb_s, diff_s;
  logic             cout_s, chunk_lt_s, chunk_eq_s;
  logic             dec_s, fin_lt_s, fin_eq_s;

  assign ca_s = a_q[idx_q*CHUNK +: CHUNK];
  assign cb_s = b_q[idx_q*CHUNK +: CHUNK];

  adder_n #(.W(CHUNK)) u_add (
    .x    (ca_s),
    .y    (~cb_s),
    .cin  (1'b1),
    .s    (diff_s),
    .cout (cout_s)
  );

  // No carry out of a + ~b + 1 means the chunk of A is below the chunk of B.
  assign chunk_lt_s = ~cout_s;
  assign chunk_eq_s = (diff_s == {CHUNK{1'b0}});

`ifdef SLT_ITER_EARLY_EXIT_EN
  assign dec_s    = !chunk_eq_s || (idx_q == {IW{1'b0}});
  assign fin_lt_s = chunk_lt_s;
  assign fin_eq_s = chunk_eq_s;
`else
  logic found_q, st_lt_q;

  assign dec_s    = (idx_q == {IW{1'b0}});
  assign fin_eq_s = !found_q && chunk_eq_s;
  assign fin_lt_s = found_q ? st_lt_q : chunk_lt_s;

  // Sticky capture of the most significant differing chunk while the scan runs on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      found_q <= 1'b0;
      st_lt_q <= 1'b0;
    end else if (state_q == S_IDLE) begin
      found_q <= 1'b0;
      st_lt_q <= 1'b0;
    end else if (state_q == S_BUSY && !found_q && !chunk_eq_s) begin
      found_q <= 1'b1;
      st_lt_q <= chunk_lt_s;
    end else begin
      found_q <= found_q;
      st_lt_q <= st_lt_q;
    end
  end
`endif

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      idx_q       <= {IW{1'b0}};
      a_q         <= {N{1'b0}};
      b_q         <= {N{1'b0}};
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      gt_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            // Flipping both sign bits maps two's-complement order onto unsigned order.
            a_q        <= a ^ (is_signed ? MSB_MASK : {N{1'b0}});
            b_q        <= b ^ (is_signed ? MSB_MASK : {N{1'b0}});
            idx_q      <= IDX_TOP;
            in_ready_q <= 1'b0;
            state_q    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (dec_s) begin
            lt_q        <= fin_lt_s;
            eq_q        <= fin_eq_s;
            gt_q        <= !fin_lt_s && !fin_eq_s;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            idx_q <= idx_q - IW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
            gt_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          lt_q        <= 1'b0;
          eq_q        <= 1'b0;
          gt_q        <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign lt        = lt_q;
  assign eq        = eq_q;
  assign gt        = gt_q;
endmodule

// File: tb/tb_slt_iter.sv
// Randomised self-checking bench for slt_iter against an arithmetic reference model.
// Expected latency follows SLT_ITER_EARLY_EXIT_EN the same way the design does.
module tb_slt_iter;
  localparam int N     = 32;
  localparam int CHUNK = 8;
  localparam int NC    = N / CHUNK;
`ifdef SLT_ITER_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         is_signed = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         lt, eq, gt;
  int           errors = 0;
  int           checks = 0;
  bit           mon_en = 1'b0;

  always #5 clk = ~clk;

  slt_iter #(.N(N), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lt        (lt),
    .eq        (eq),
    .gt        (gt)
  );

  function automatic logic [2:0] ref_res(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
    logic l, e;
    if (s) l = ($signed(x) < $signed(y));
    else   l = (x < y);
    e = (x == y);
    return {l, e, !l && !e};
  endfunction

  function automatic int ref_lat(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [N-1:0] d;
    if (!EARLY) return NC;
    for (int k = NC - 1; k >= 0; k--) begin
      d = (x ^ y) >> (k * CHUNK);
      if (d[CHUNK-1:0] != '0) return NC - k;
    end
    return NC;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (out_valid ? (int'(lt) + int'(eq) + int'(gt) != 1) : (lt | eq | gt)) begin
        errors++;
        $display("FAIL onehot: out_valid=%b lt/eq/gt=%b%b%b, required one-hot when valid else 000",
                 out_valid, lt, eq, gt);
      end
    end
  end

  task automatic run_cmp(input logic [N-1:0] x, input logic [N-1:0] y, input logic s,
                         input bit early_rdy, input int hold, input bit junk, input string tag);
    logic [2:0] exp_r, got_r;
    int lat, exp_lat;
    exp_r   = ref_res(x, y, s);
    exp_lat = ref_lat(x, y);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s in_ready_idle: got %b want 1", tag, in_ready);
    end
    a = x; b = y; is_signed = s; in_valid = 1'b1;
    @(negedge clk);
    in_valid = junk; a = $urandom; b = $urandom; is_signed = 1'($urandom_range(0, 1));
    out_ready = early_rdy;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    got_r = {lt, eq, gt};
    checks++;
    if (got_r !== exp_r) begin
      errors++; $display("FAIL %s result: a=%h b=%h s=%b got lt/eq/gt=%b want %b", tag, x, y, s, got_r, exp_r);
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++; $display("FAIL %s latency: a=%h b=%h got %0d want %0d", tag, x, y, lat, exp_lat);
    end
    if (!early_rdy) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        checks++;
        if ({out_valid, lt, eq, gt, in_ready} !== {1'b1, exp_r, 1'b0}) begin
          errors++; $display("FAIL %s hold: got v/lt/eq/gt/rdy=%b want %b", tag,
                             {out_valid, lt, eq, gt, in_ready}, {1'b1, exp_r, 1'b0});
        end
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({out_valid, lt, eq, gt, in_ready} !== 5'b00001) begin
      errors++; $display("FAIL %s release: got v/lt/eq/gt/rdy=%b want 00001", tag,
                         {out_valid, lt, eq, gt, in_ready});
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, lt, eq, gt} !== 5'b00000) begin
      errors++; $display("FAIL reset_state: got rdy/v/lt/eq/gt=%b want 00000", {in_ready, out_valid, lt, eq, gt});
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release: in_ready got %b want 1", in_ready);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_vectors();
    run_cmp(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 0, 1'b0, "neg1_signed");
    run_cmp(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0, "neg1_unsigned");
    run_cmp(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 0, 1'b0, "eq_signed");
    run_cmp(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 0, 1'b0, "eq_unsigned");
    run_cmp(32'h0100_0000, 32'h0000_0000, 1'b0, 1'b0, 0, 1'b0, "top_chunk_gt");
    run_cmp(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 0, 1'b0, "min_vs_max");
    run_cmp(32'h1234_5600, 32'h1234_5601, 1'b0, 1'b1, 0, 1'b0, "low_chunk_lt");
  endtask

  task automatic test_back_pressure();
    run_cmp(32'h0000_0042, 32'h0000_0017, 1'b1, 1'b0, 5, 1'b1, "back_pressure");
  endtask

  task automatic test_reset_busy();
    int w;
    @(negedge clk);
    a = 32'hCAFE_0000; b = 32'hCAFE_0000; is_signed = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, lt, eq, gt} !== 5'b00000) begin
      errors++; $display("FAIL reset_busy: got rdy/v/lt/eq/gt=%b want 00000", {in_ready, out_valid, lt, eq, gt});
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (NC + 2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_discard: out_valid got %b want 0", out_valid);
    end
    run_cmp(32'd5, 32'd7, 1'b1, 1'b0, 1, 1'b0, "after_reset_5_7");
    @(negedge clk);
    a = 32'd9; b = 32'd3; is_signed = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (out_valid !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, lt, eq, gt} !== 4'b0000) begin
      errors++; $display("FAIL reset_done: got v/lt/eq/gt=%b want 0000 (waited %0d)", {out_valid, lt, eq, gt}, w);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [N-1:0] x, y, m;
    for (int i = 0; i < 1200; i++) begin
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = $urandom;
        1: y = x;
        2: y = x ^ (N'(1) << $urandom_range(0, N - 1));
        default: begin
          m = {N{1'b1}} >> $urandom_range(0, N - 1);
          y = x ^ (N'($urandom) & m);
        end
      endcase
      run_cmp(x, y, 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
              $urandom_range(0, 2), bit'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_pressure();
    test_reset_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
